// File: rtl/line_seq_ctrl.sv
// Line sequencer for a 5x5 line-buffer filter: turns raw HDMI dv/vs into
// BRAM write addresses, row/column tracking and a kernel-valid flag.
module line_seq_ctrl #(
   parameter int ADDR_W   = 11,
   parameter int MIN_ROWS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_dv,
   input  logic              rx_hs,
   input  logic              rx_vs,
   input  logic              bypass_req,
   output logic [ADDR_W-1:0] addr,
   output logic              bram_we,
   output logic [ADDR_W-1:0] row,
   output logic [ADDR_W-1:0] col,
   output logic [ADDR_W-1:0] line_width,
   output logic              kernel_valid,
   output logic              frame_start,
   output logic              bypass_active,
   output logic              err_overflow
);

   typedef enum logic [1:0] {WAIT_VS, FRAME, LINE, HBLANK} state_t;

   localparam logic [ADDR_W-1:0] MAX_IDX   = '1;
   localparam logic [ADDR_W-1:0] ROW_MIN   = ADDR_W'(MIN_ROWS);
   localparam logic [ADDR_W-1:0] COL_MIN   = ADDR_W'(4);

   state_t              state_q, state_d;
   logic                dv_r, vs_r, dv_prev_q, vs_prev_q;
   logic                hs_r_unused;
   logic [ADDR_W-1:0]   addr_q, addr_d, row_q, row_d, col_q, col_d;
   logic [ADDR_W-1:0]   line_width_q, line_width_d;
   logic                bram_we_q, bram_we_d, kernel_valid_q, kernel_valid_d;
   logic                frame_start_q, frame_start_d;
   logic                bypass_active_q, bypass_active_d;
   logic                err_overflow_q, err_overflow_d;
   logic                dv_rise, dv_fall, vs_rise;

   always_comb begin
      dv_rise         = dv_r & ~dv_prev_q;
      dv_fall         = ~dv_r & dv_prev_q;
      vs_rise         = vs_r & ~vs_prev_q;
      state_d         = state_q;
      addr_d          = addr_q;
      row_d           = row_q;
      col_d           = col_q;
      line_width_d    = line_width_q;
      bram_we_d       = 1'b0;
      frame_start_d   = 1'b0;
      bypass_active_d = bypass_active_q;
      err_overflow_d  = err_overflow_q;

      // Vsync restarts the frame from any state and outranks a coincident dv edge.
      if (vs_rise) begin
         state_d         = FRAME;
         addr_d          = '0;
         row_d           = '0;
         col_d           = '0;
         frame_start_d   = 1'b1;
         err_overflow_d  = 1'b0;
         bypass_active_d = bypass_req;
      end else begin
         case (state_q)
            FRAME, HBLANK: begin
               if (dv_rise) begin
                  state_d   = LINE;
                  addr_d    = '0;
                  col_d     = '0;
                  bram_we_d = 1'b1;
               end
            end
            LINE: begin
               if (dv_fall) begin
                  state_d      = HBLANK;
                  line_width_d = (col_q == MAX_IDX) ? MAX_IDX : col_q + 1'b1;
                  row_d        = (row_q == MAX_IDX) ? row_q : row_q + 1'b1;
               end else if (col_q == MAX_IDX) begin
                  err_overflow_d = 1'b1;
               end else begin
                  col_d     = col_q + 1'b1;
                  addr_d    = col_q + 1'b1;
                  bram_we_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      kernel_valid_d = bram_we_d && (row_q >= ROW_MIN) && (col_d >= COL_MIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= WAIT_VS;
         dv_r            <= 1'b0;
         hs_r_unused     <= 1'b0;
         vs_r            <= 1'b0;
         dv_prev_q       <= 1'b0;
         vs_prev_q       <= 1'b0;
         addr_q          <= '0;
         row_q           <= '0;
         col_q           <= '0;
         line_width_q    <= '0;
         bram_we_q       <= 1'b0;
         kernel_valid_q  <= 1'b0;
         frame_start_q   <= 1'b0;
         bypass_active_q <= 1'b0;
         err_overflow_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         dv_r            <= rx_dv;
         hs_r_unused     <= rx_hs;
         vs_r            <= rx_vs;
         dv_prev_q       <= dv_r;
         vs_prev_q       <= vs_r;
         addr_q          <= addr_d;
         row_q           <= row_d;
         col_q           <= col_d;
         line_width_q    <= line_width_d;
         bram_we_q       <= bram_we_d;
         kernel_valid_q  <= kernel_valid_d;
         frame_start_q   <= frame_start_d;
         bypass_active_q <= bypass_active_d;
         err_overflow_q  <= err_overflow_d;
      end
   end

   assign addr          = addr_q;
   assign bram_we       = bram_we_q;
   assign row           = row_q;
   assign col           = col_q;
   assign line_width    = line_width_q;
   assign kernel_valid  = kernel_valid_q;
   assign frame_start   = frame_start_q;
   assign bypass_active = bypass_active_q;
   assign err_overflow  = err_overflow_q;

endmodule
